// File: rtl/synth_voice_pkg.sv
// Shared types for the voice allocator: FSM states, velocity default and table entry layout.
package synth_voice_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StSetup,
    StStrobe,
    StHold
  } alloc_state_t;

  localparam logic [7:0] VEL_DEFAULT = 8'hff;
  localparam int unsigned AGE_W_DEFAULT = 8;

  typedef struct packed {
    logic                     active;
    logic [6:0]               key;
    logic [AGE_W_DEFAULT-1:0] age;
  } voice_entry_t;

endpackage

// File: rtl/voice_scan.sv
// Sequential comparator: walks one voice per cycle and tracks the first key match,
// the lowest free voice and the oldest active voice. Outputs include the current voice.
module voice_scan #(
  parameter int unsigned VWidth = 5,
  parameter int unsigned AgeW   = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [VWidth-1:0] idx_i,
  input  logic              cur_active_i,
  input  logic [6:0]        cur_key_i,
  input  logic [AgeW-1:0]   cur_age_i,
  input  logic [6:0]        key_i,
  output logic              match_vld_o,
  output logic [VWidth-1:0] match_idx_o,
  output logic              free_vld_o,
  output logic [VWidth-1:0] free_idx_o,
  output logic [VWidth-1:0] old_idx_o
);

  logic              match_vld_q, match_vld_d;
  logic [VWidth-1:0] match_idx_q, match_idx_d;
  logic              free_vld_q, free_vld_d;
  logic [VWidth-1:0] free_idx_q, free_idx_d;
  logic              old_vld_q, old_vld_d;
  logic [VWidth-1:0] old_idx_q, old_idx_d;
  logic [AgeW-1:0]   old_age_q, old_age_d;

  always_comb begin
    match_vld_d = match_vld_q;
    match_idx_d = match_idx_q;
    free_vld_d  = free_vld_q;
    free_idx_d  = free_idx_q;
    old_vld_d   = old_vld_q;
    old_idx_d   = old_idx_q;
    old_age_d   = old_age_q;
    if (en_i) begin
      if (cur_active_i && (cur_key_i == key_i) && !match_vld_q) begin
        match_vld_d = 1'b1;
        match_idx_d = idx_i;
      end
      if (!cur_active_i && !free_vld_q) begin
        free_vld_d = 1'b1;
        free_idx_d = idx_i;
      end
      // Strictly greater keeps the lowest index on an age tie.
      if (cur_active_i && (!old_vld_q || (cur_age_i > old_age_q))) begin
        old_vld_d = 1'b1;
        old_idx_d = idx_i;
        old_age_d = cur_age_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      match_vld_q <= 1'b0;
      match_idx_q <= '0;
      free_vld_q  <= 1'b0;
      free_idx_q  <= '0;
      old_vld_q   <= 1'b0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
    end else begin
      match_vld_q <= match_vld_d;
      match_idx_q <= match_idx_d;
      free_vld_q  <= free_vld_d;
      free_idx_q  <= free_idx_d;
      old_vld_q   <= old_vld_d;
      old_idx_q   <= old_idx_d;
      old_age_q   <= old_age_d;
    end
  end

  assign match_vld_o = match_vld_d;
  assign match_idx_o = match_idx_d;
  assign free_vld_o  = free_vld_d;
  assign free_idx_o  = free_idx_d;
  assign old_idx_o   = old_idx_d;

endmodule

// File: rtl/voice_allocator.sv
// Turns MIDI note events into voice assignments and drives the per-voice note-on
// register interface (adr/vel/key settled around a single-cycle strobe).
module voice_allocator
  import synth_voice_pkg::*;
#(
  parameter int unsigned VOICES  = 32,
  parameter int unsigned V_WIDTH = 5,
  parameter int unsigned AGE_W   = 8
) (
  input  logic               sCLK_XVXENVS,
  input  logic               reset_reg_N,
  input  logic               evt_valid,
  output logic               evt_ready,
  input  logic               evt_on,
  input  logic [6:0]         evt_key,
  input  logic [7:0]         evt_vel,
  output logic               reg_note_on,
  output logic               reg_note_off,
  output logic [V_WIDTH-1:0] reg_cur_key_adr,
  output logic [7:0]         reg_cur_vel_on,
  output logic [6:0]         reg_cur_key,
  output logic [VOICES-1:0]  voice_active
);

  alloc_state_t       state_q, state_d;
  logic [V_WIDTH-1:0] idx_q, idx_d;
  logic               ev_on_q, ev_on_d;
  logic [6:0]         ev_key_q, ev_key_d;
  logic [7:0]         ev_vel_q, ev_vel_d;
  logic               ready_q, ready_d;
  logic               note_on_q, note_on_d;
  logic               note_off_q, note_off_d;
  logic [V_WIDTH-1:0] adr_q, adr_d;
  logic [7:0]         vel_q, vel_d;
  logic [6:0]         key_q, key_d;

  logic [VOICES-1:0]  tbl_active_q;
  logic [6:0]         tbl_key_q [VOICES];
  logic [AGE_W-1:0]   tbl_age_q [VOICES];

  logic               accept, scan_last;
  logic               match_vld, free_vld;
  logic [V_WIDTH-1:0] match_idx, free_idx, old_idx;

  assign accept    = evt_valid && ready_q;
  assign scan_last = (idx_q == V_WIDTH'(VOICES - 1));

  voice_scan #(
    .VWidth(V_WIDTH),
    .AgeW  (AGE_W)
  ) u_scan (
    .clk_i       (sCLK_XVXENVS),
    .rst_ni      (reset_reg_N),
    .clr_i       (accept),
    .en_i        (state_q == StScan),
    .idx_i       (idx_q),
    .cur_active_i(tbl_active_q[idx_q]),
    .cur_key_i   (tbl_key_q[idx_q]),
    .cur_age_i   (tbl_age_q[idx_q]),
    .key_i       (ev_key_q),
    .match_vld_o (match_vld),
    .match_idx_o (match_idx),
    .free_vld_o  (free_vld),
    .free_idx_o  (free_idx),
    .old_idx_o   (old_idx)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ev_on_d    = ev_on_q;
    ev_key_d   = ev_key_q;
    ev_vel_d   = ev_vel_q;
    ready_d    = ready_q;
    note_on_d  = 1'b0;
    note_off_d = 1'b0;
    adr_d      = adr_q;
    vel_d      = vel_q;
    key_d      = key_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // Velocity 0 on a note-on is a note-off.
          ev_on_d  = evt_on && (evt_vel != 8'd0);
          ev_key_d = evt_key;
          ev_vel_d = evt_vel;
          idx_d    = '0;
          ready_d  = 1'b0;
          state_d  = StScan;
        end
      end
      StScan: begin
        idx_d = idx_q + 1'b1;
        if (scan_last) begin
          if (ev_on_q || match_vld) begin
            adr_d   = match_vld ? match_idx : (free_vld ? free_idx : old_idx);
            vel_d   = ev_vel_q;
            key_d   = ev_key_q;
            state_d = StSetup;
          end else begin
            ready_d = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StSetup: begin
        note_on_d  = ev_on_q;
        note_off_d = !ev_on_q;
        state_d    = StStrobe;
      end
      StStrobe: state_d = StHold;
      StHold: begin
        ready_d = 1'b1;
        state_d = StIdle;
      end
      default: begin
        ready_d = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge sCLK_XVXENVS) begin
    if (!reset_reg_N) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      ev_on_q    <= 1'b0;
      ev_key_q   <= '0;
      ev_vel_q   <= '0;
      ready_q    <= 1'b1;
      note_on_q  <= 1'b0;
      note_off_q <= 1'b0;
      adr_q      <= '0;
      vel_q      <= VEL_DEFAULT;
      key_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ev_on_q    <= ev_on_d;
      ev_key_q   <= ev_key_d;
      ev_vel_q   <= ev_vel_d;
      ready_q    <= ready_d;
      note_on_q  <= note_on_d;
      note_off_q <= note_off_d;
      adr_q      <= adr_d;
      vel_q      <= vel_d;
      key_q      <= key_d;
    end
  end

  // Table commits on the same edge that raises the strobe.
  always_ff @(posedge sCLK_XVXENVS) begin
    if (!reset_reg_N) begin
      tbl_active_q <= '0;
      for (int unsigned i = 0; i < VOICES; i++) begin
        tbl_key_q[i] <= '0;
        tbl_age_q[i] <= '0;
      end
    end else if (state_q == StSetup) begin
      if (ev_on_q) begin
        for (int unsigned i = 0; i < VOICES; i++) begin
          if (V_WIDTH'(i) == adr_q) begin
            tbl_active_q[i] <= 1'b1;
            tbl_key_q[i]    <= ev_key_q;
            tbl_age_q[i]    <= '0;
          end else if (tbl_active_q[i] && (tbl_age_q[i] != {AGE_W{1'b1}})) begin
            tbl_age_q[i] <= tbl_age_q[i] + 1'b1;
          end
        end
      end else begin
        tbl_active_q[adr_q] <= 1'b0;
      end
    end
  end

  assign evt_ready       = ready_q;
  assign reg_note_on     = note_on_q;
  assign reg_note_off    = note_off_q;
  assign reg_cur_key_adr = adr_q;
  assign reg_cur_vel_on  = vel_q;
  assign reg_cur_key     = key_q;
  assign voice_active    = tbl_active_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with 4 voices: allocation, retrigger, steal,
// note-off, unmatched note-off, mid-scan reset and held-valid backpressure.
module tb_voice_allocator;

  localparam int V = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       evt_valid, evt_ready, evt_on;
  logic [6:0] evt_key;
  logic [7:0] evt_vel;
  logic       note_on, note_off;
  logic [1:0] adr;
  logic [7:0] vel;
  logic [6:0] key;
  logic [3:0] active;

  int n_tests = 0;
  int n_fail  = 0;

  int         r_on, r_off, r_cyc;
  logic [1:0] r_adr;
  logic [7:0] r_vel;
  logic [6:0] r_key;
  bit         r_stable;
  bit [8:1]   r_rdy;

  int         acc_cnt   = 0;
  int         on_pulses = 0;
  logic [1:0] last_adr;
  logic [6:0] last_key;

  always #5 clk = ~clk;

  voice_allocator #(
    .VOICES (V),
    .V_WIDTH(2),
    .AGE_W  (8)
  ) dut (
    .sCLK_XVXENVS   (clk),
    .reset_reg_N    (rst_n),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_on         (evt_on),
    .evt_key        (evt_key),
    .evt_vel        (evt_vel),
    .reg_note_on    (note_on),
    .reg_note_off   (note_off),
    .reg_cur_key_adr(adr),
    .reg_cur_vel_on (vel),
    .reg_cur_key    (key),
    .voice_active   (active)
  );

  always @(posedge clk) if (rst_n && evt_valid && evt_ready) acc_cnt++;

  always @(negedge clk) begin
    if (note_on) begin
      on_pulses++;
      last_adr = adr;
      last_key = key;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one event, then watch V+4 cycles, cycle 1 being the one after the accept edge.
  task automatic do_event(input bit on, input logic [6:0] k, input logic [7:0] v);
    int w = 0;
    logic [16:0] snap = '0;
    @(negedge clk);
    evt_valid = 1'b1;
    evt_on    = on;
    evt_key   = k;
    evt_vel   = v;
    while (!evt_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_eq("accept_wait", 32'(w < 20), 32'd1);
    @(posedge clk);
    #1 evt_valid = 1'b0;
    r_on = 0; r_off = 0; r_cyc = 0; r_stable = 1'b1; r_rdy = '0;
    for (int c = 1; c <= V + 4; c++) begin
      @(negedge clk);
      r_rdy[c] = evt_ready;
      if (c == V + 1) snap = {adr, vel, key};
      if ((c == V + 2 || c == V + 3) && ({adr, vel, key} != snap)) r_stable = 1'b0;
      if (note_on) begin
        r_on++; r_cyc = c; r_adr = adr; r_vel = vel; r_key = key;
      end
      if (note_off) begin
        r_off++; r_cyc = c; r_adr = adr;
      end
    end
  endtask

  task automatic expect_on(input string tag, input int a, input int v, input int k, input int act);
    check_eq({tag, "_on_cnt"}, r_on, 1);
    check_eq({tag, "_off_cnt"}, r_off, 0);
    check_eq({tag, "_latency"}, r_cyc, V + 2);
    check_eq({tag, "_adr"}, r_adr, a);
    check_eq({tag, "_vel"}, r_vel, v);
    check_eq({tag, "_key"}, r_key, k);
    check_eq({tag, "_stable"}, r_stable, 1);
    check_eq({tag, "_ready"}, r_rdy, 8'h80);
    check_eq({tag, "_active"}, active, act);
  endtask

  initial begin
    int w;
    int a0, p0, cnt;
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int w, a0, p0, cnt;
    rst_n = 1'b0; evt_valid = 1'b0; evt_on = 1'b0; evt_key = '0; evt_vel = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", evt_ready, 1);
    check_eq("rst_vel", vel, 8'hff);
    check_eq("rst_note_on", note_on, 0);
    check_eq("rst_note_off", note_off, 0);
    check_eq("rst_adr", adr, 0);
    check_eq("rst_key", key, 0);
    check_eq("rst_active", active, 0);
    rst_n = 1'b1;

    do_event(1, 60, 100); expect_on("on60", 0, 100, 60, 4'b0001);
    do_event(1, 60, 50);  expect_on("retrig60", 0, 50, 60, 4'b0001);
    do_event(1, 60, 70);  expect_on("again60", 0, 70, 60, 4'b0001);
    do_event(1, 62, 70);  expect_on("on62", 1, 70, 62, 4'b0011);
    do_event(1, 64, 70);  expect_on("on64", 2, 70, 64, 4'b0111);
    do_event(1, 65, 70);  expect_on("on65", 3, 70, 65, 4'b1111);
    do_event(1, 67, 90);  expect_on("steal67", 0, 90, 67, 4'b1111);

    do_event(1, 62, 0);
    check_eq("off62_on_cnt", r_on, 0);
    check_eq("off62_off_cnt", r_off, 1);
    check_eq("off62_latency", r_cyc, V + 2);
    check_eq("off62_adr", r_adr, 1);
    check_eq("off62_active", active, 4'b1101);

    do_event(1, 70, 40); expect_on("on70", 1, 40, 70, 4'b1111);

    do_event(0, 99, 0);
    check_eq("off99_strobes", r_on + r_off, 0);
    check_eq("off99_ready", r_rdy, 8'hf0);
    check_eq("off99_active", active, 4'b1111);

    do_event(1, 67, 11); expect_on("retrig67", 0, 11, 67, 4'b1111);
    do_event(1, 80, 12); expect_on("steal80", 2, 12, 80, 4'b1111);

    // Reset two cycles into SCAN.
    @(negedge clk);
    evt_valid = 1'b1; evt_on = 1'b1; evt_key = 7'd90; evt_vel = 8'd20;
    @(posedge clk);
    #1 evt_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_ready", evt_ready, 1);
    check_eq("midrst_vel", vel, 8'hff);
    check_eq("midrst_note_on", note_on, 0);
    check_eq("midrst_adr", adr, 0);
    check_eq("midrst_key", key, 0);
    check_eq("midrst_active", active, 0);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < V + 4; c++) begin
      @(negedge clk);
      if (note_on || note_off) cnt++;
    end
    check_eq("midrst_no_strobe", cnt, 0);
    do_event(1, 90, 20); expect_on("post_rst90", 0, 20, 90, 4'b0001);

    // Valid held through a busy period: second event accepted exactly once.
    a0 = acc_cnt;
    p0 = on_pulses;
    @(negedge clk);
    evt_valid = 1'b1; evt_on = 1'b1; evt_key = 7'd91; evt_vel = 8'd30;
    w = 0;
    while (acc_cnt == a0 && w < 20) begin
      @(posedge clk);
      #1 w++;
    end
    evt_key = 7'd92; evt_vel = 8'd31;
    @(negedge clk);
    check_eq("busy_ready", evt_ready, 0);
    w = 0;
    while (acc_cnt == a0 + 1 && w < 20) begin
      @(posedge clk);
      #1 w++;
    end
    evt_valid = 1'b0;
    check_eq("throughput", w, V + 4);
    repeat (V + 6) @(negedge clk);
    check_eq("held_accepts", acc_cnt - a0, 2);
    check_eq("held_pulses", on_pulses - p0, 2);
    check_eq("held_last_adr", last_adr, 2);
    check_eq("held_last_key", last_key, 92);
    check_eq("held_active", active, 4'b0111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
